// File: rtl/converter_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per cycle.
// Optional macro BCD_SIGNED_EN: treat in_bin as two's complement and report the sign on out_neg.
module converter_bcd_seq #(
  parameter int BIN_W    = 32,
  parameter int N_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        in_bin,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*N_DIGITS-1:0]   out_bcd,
  output logic                    out_ovf
`ifdef BCD_SIGNED_EN
  ,
  output logic                    out_neg
`endif
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic               ovf_reg;

  logic [BIN_W-1:0]   operand_in;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shifted;
  logic [BIN_W-1:0]   bin_shifted;
  logic               carry_out;

`ifdef BCD_SIGNED_EN
  logic               neg_reg;

  // Two's-complement negate; the most negative value maps onto its own bit
  // pattern, which read as unsigned is exactly 2^(BIN_W-1).
  assign operand_in = in_bin[BIN_W-1] ? ((~in_bin) + {{(BIN_W-1){1'b0}}, 1'b1}) : in_bin;
  assign out_neg    = neg_reg;
`else
  assign operand_in = in_bin;
`endif

  // Add-3 correction works on the digit values held before this cycle's shift.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    logic [3:0] digit;
    assign digit                  = bcd_reg[4*gi +: 4];
    assign bcd_adj[4*gi +: 4]     = (digit >= 4'd5) ? (digit + 4'd3) : digit;
  end

  assign bcd_shifted = {bcd_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
  assign bin_shifted = {bin_reg[BIN_W-2:0], 1'b0};
  assign carry_out   = bcd_adj[BCD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
      bin_reg       <= '0;
      bcd_reg       <= '0;
      ovf_reg       <= 1'b0;
`ifdef BCD_SIGNED_EN
      neg_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg    <= SHIFT;
            in_ready_reg <= 1'b0;
            bin_reg      <= operand_in;
            bcd_reg      <= '0;
            ovf_reg      <= 1'b0;
            cnt_reg      <= '0;
`ifdef BCD_SIGNED_EN
            neg_reg      <= in_bin[BIN_W-1];
`endif
          end
        end
        SHIFT: begin
          if (abort) begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b1;
          end else begin
            bcd_reg <= bcd_shifted;
            bin_reg <= bin_shifted;
            ovf_reg <= ovf_reg | carry_out;
            cnt_reg <= cnt_reg + CNT_ONE;
            if (cnt_reg == LAST_CNT) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          // Abort has no meaning once the result is held; only out_ready releases it.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_bcd   = bcd_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_converter_bcd_seq.sv
// Bench for converter_bcd_seq: default instance plus an 8-bit/2-digit instance,
// checked against a decimal-arithmetic reference model.
module tb_converter_bcd_seq;

  localparam int AW = 32;
  localparam int AN = 10;
  localparam int BW = 8;
  localparam int BN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          a_in_valid, a_in_ready, a_abort, a_out_valid, a_out_ready, a_out_ovf;
  logic [AW-1:0] a_in_bin;
  logic [4*AN-1:0] a_out_bcd;

  logic          b_in_valid, b_in_ready, b_abort, b_out_valid, b_out_ready, b_out_ovf;
  logic [BW-1:0] b_in_bin;
  logic [4*BN-1:0] b_out_bcd;

`ifdef BCD_SIGNED_EN
  logic a_out_neg, b_out_neg;
`endif

  converter_bcd_seq #(.BIN_W(AW), .N_DIGITS(AN)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_bin(a_in_bin), .abort(a_abort), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_bcd(a_out_bcd), .out_ovf(a_out_ovf)
`ifdef BCD_SIGNED_EN
    , .out_neg(a_out_neg)
`endif
  );

  converter_bcd_seq #(.BIN_W(BW), .N_DIGITS(BN)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_bin(b_in_bin), .abort(b_abort), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_bcd(b_out_bcd), .out_ovf(b_out_ovf)
`ifdef BCD_SIGNED_EN
    , .out_neg(b_out_neg)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division; overflow if anything remains.
  task automatic model(input logic [63:0] v, input int w, input int n,
                       output logic [79:0] bcd, output logic ovf, output logic neg);
    logic [63:0] mask;
    logic [63:0] mag;
    mask = {64{1'b1}} >> (64 - w);
    mag  = v & mask;
    neg  = 1'b0;
`ifdef BCD_SIGNED_EN
    if (mag[w-1]) begin
      neg = 1'b1;
      mag = (64'd1 << w) - mag;
    end
`endif
    bcd = '0;
    for (int i = 0; i < n; i++) begin
      bcd[4*i +: 4] = 4'(mag % 64'd10);
      mag = mag / 64'd10;
    end
    ovf = (mag != 64'd0);
  endtask

  function automatic logic [79:0] obs_bcd(input bit sel);
    return sel ? {72'd0, b_out_bcd} : {40'd0, a_out_bcd};
  endfunction
  function automatic logic obs_valid(input bit sel);
    return sel ? b_out_valid : a_out_valid;
  endfunction
  function automatic logic obs_ready(input bit sel);
    return sel ? b_in_ready : a_in_ready;
  endfunction
  function automatic logic obs_ovf(input bit sel);
    return sel ? b_out_ovf : a_out_ovf;
  endfunction
`ifdef BCD_SIGNED_EN
  function automatic logic obs_neg(input bit sel);
    return sel ? b_out_neg : a_out_neg;
  endfunction
`endif

  task automatic drive(input bit sel, input logic iv, input logic [63:0] v,
                       input logic ordy, input logic ab);
    if (sel) begin
      b_in_valid = iv; b_in_bin = v[BW-1:0]; b_out_ready = ordy; b_abort = ab;
    end else begin
      a_in_valid = iv; a_in_bin = v[AW-1:0]; a_out_ready = ordy; a_abort = ab;
    end
  endtask

  // One full transaction: accept, latency, result, hold in DONE, release.
  task automatic convert(input bit sel, input logic [63:0] v, input int hold);
    int w, n, lat;
    logic [79:0] eb, held;
    logic eo, en;
    w = sel ? BW : AW;
    n = sel ? BN : AN;
    model(v, w, n, eb, eo, en);
    chk("ready_before_accept", obs_ready(sel), 1);
    drive(sel, 1'b1, v, 1'b0, 1'b0);
    step();
    drive(sel, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("busy_after_accept", obs_ready(sel), 0);
    lat = 0;
    while (!obs_valid(sel) && lat < 200) begin
      step();
      lat++;
    end
    chk("latency", lat, w);
    chk("bcd", obs_bcd(sel), eb);
    chk("ovf", obs_ovf(sel), eo);
`ifdef BCD_SIGNED_EN
    chk("neg", obs_neg(sel), en);
`endif
    $display("conv sel=%0d in=%0h bcd=%0h ovf=%0d latency=%0d", sel, v, obs_bcd(sel), obs_ovf(sel), lat);
    held = obs_bcd(sel);
    for (int k = 0; k < hold; k++) begin
      drive(sel, 1'b1, {32'd0, $urandom}, 1'b0, 1'b1);
      step();
      chk("hold_valid", obs_valid(sel), 1);
      chk("hold_bcd", obs_bcd(sel), held);
      chk("hold_ovf", obs_ovf(sel), eo);
      chk("hold_in_ready", obs_ready(sel), 0);
    end
    drive(sel, 1'b0, 64'd0, 1'b1, (hold > 0));
    step();
    drive(sel, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("release_valid", obs_valid(sel), 0);
    chk("release_ready", obs_ready(sel), 1);
  endtask

  initial begin
    logic [79:0] eb;
    logic eo, en;
    int n;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
    #12;
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_bcd", a_out_bcd, 0);
    chk("rst_a_ovf", a_out_ovf, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
`ifdef BCD_SIGNED_EN
    chk("rst_a_neg", a_out_neg, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Full-scale operand, then a long stall in DONE with in_valid/abort noise.
    convert(1'b0, 64'hFFFF_FFFF, 20);
    convert(1'b0, 64'd0, 0);
    convert(1'b0, 64'h8000_0000, 1);

    // Back-to-back with out_ready held high: accepts are AW+2 edges apart.
    chk("b2b_ready", a_in_ready, 1);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_bin    = 32'd0;
    step();
    a_in_bin = 32'd1000000007;
    chk("b2b_busy", a_in_ready, 0);
    n = 0;
    while (!a_out_valid && n < 200) begin
      step();
      n++;
    end
    chk("b2b_first_latency", n, AW);
    chk("b2b_first_bcd", a_out_bcd, 0);
    step();
    chk("b2b_idle_gap", a_in_ready, 1);
    step();
    chk("b2b_second_accept", a_in_ready, 0);
    a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 200) begin
      step();
      n++;
    end
    model(64'd1000000007, AW, AN, eb, eo, en);
    chk("b2b_second_latency", n, AW);
    chk("b2b_second_bcd", a_out_bcd, eb);
    $display("b2b second bcd=%0h", a_out_bcd);
    step();
    a_out_ready = 1'b0;
    chk("b2b_release", a_in_ready, 1);

    // Narrow instance: overflow keeps the low digits.
    convert(1'b1, 64'd255, 2);
    convert(1'b1, 64'd99, 0);
    convert(1'b1, 64'd0, 1);
    for (int i = 0; i < 8; i++) convert(1'b1, {32'd0, $urandom_range(0, 255)}, int'($urandom_range(0, 2)));

    // Abort after 10 shifts.
    a_in_valid = 1'b1;
    a_in_bin   = $urandom;
    step();
    a_in_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    chk("abort_in_ready", a_in_ready, 1);
    chk("abort_out_valid", a_out_valid, 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (a_out_valid) n++;
    end
    chk("abort_no_valid", n, 0);
    $display("abort done in_ready=%0d", a_in_ready);

    // Reset after 5 shifts of the next operand.
    a_in_valid = 1'b1;
    a_in_bin   = $urandom;
    step();
    a_in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", a_in_ready, 1);
    chk("midreset_out_valid", a_out_valid, 0);
    chk("midreset_bcd", a_out_bcd, 0);
    chk("midreset_ovf", a_out_ovf, 0);
    $display("mid-shift reset in_ready=%0d", a_in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    convert(1'b0, 64'd1234567890, 0);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] r;
      r = (i % 4 == 0) ? $urandom_range(0, 999) : $urandom;
      convert(1'b0, {32'd0, r}, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/converter_bcd_seq.md
CONVERTER_BCD_SEQ -- requirements
Module: converter_bcd_seq

Interface
REQ-001 Parameter BIN_W, default 32: binary input width, range 4..64.
REQ-002 Parameter N_DIGITS, default 10: BCD output digit count, range 1..20.
REQ-003 The clock and reset SHALL be one clock, clk, with asynchronous active-low reset rst_n.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1: in_bin is valid.
REQ-007 Port in_ready, output, 1: block can accept an operand.
REQ-008 Port in_bin, input, BIN_W: binary operand.
REQ-009 Port abort, input, 1: synchronous cancel of the conversion in progress.
REQ-010 Port out_valid, output, 1: result is held and valid.
REQ-011 Port out_ready, input, 1: consumer takes the result.
REQ-012 Port out_bcd, output, 4*N_DIGITS: packed BCD; digit k occupies bits [4k+3:4k], with the least significant digit at k=0.
REQ-013 Port out_ovf, output, 1: value exceeded N_DIGITS decimal digits.
REQ-014 Port out_neg, output, 1: sign flag; present only with BCD_SIGNED_EN.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 IDLE to SHIFT: on in_valid & in_ready, the block SHALL capture in_bin into the shift register, clear the BCD accumulator and ovf, and set the counter to 0.
REQ-018 Each SHIFT cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, operand} left by 1 bit, then increment the counter.
REQ-019 Digit correction in REQ-018 SHALL use the digit values from before the shift of that same cycle.
REQ-020 SHIFT to DONE SHALL occur on the edge that performs the BIN_W-th shift.
REQ-021 Latency: out_valid SHALL rise exactly BIN_W clock edges after the accept edge.
REQ-022 out_ovf SHALL be set sticky when a 1 is shifted out of the top digit during conversion.
REQ-023 out_bcd SHALL hold the low N_DIGITS digits regardless of out_ovf.
REQ-024 DONE to IDLE: on out_ready, the block SHALL return to IDLE; a new operand is accepted no earlier than the following cycle.
REQ-025 out_bcd, out_ovf and out_neg SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 abort in SHIFT SHALL return the FSM to IDLE on the next edge without asserting out_valid.
REQ-027 abort in IDLE or DONE SHALL be ignored; out_ready SHALL take precedence in DONE.
REQ-028 in_valid presented outside IDLE SHALL be ignored.
REQ-029 Input 0 SHALL produce all-zero out_bcd and out_ovf=0.

Reset
REQ-030 While rst_n=0, the FSM SHALL enter IDLE asynchronously and clear the counter and all data registers.
REQ-031 While rst_n=0, in_ready SHALL be 1 and out_valid, out_bcd, out_ovf and out_neg SHALL be 0.
REQ-032 Reset asserted mid-SHIFT SHALL discard the conversion.
REQ-033 After rst_n deasserts, the first accept is possible on the first rising edge.

Configuration
REQ-034 Macro BCD_SIGNED_EN, when defined, SHALL treat in_bin as two's complement.
REQ-035 With BCD_SIGNED_EN defined, the block SHALL capture |in_bin| at accept and set out_neg=in_bin[BIN_W-1].
REQ-036 With BCD_SIGNED_EN defined, -2^(BIN_W-1) SHALL convert to magnitude 2^(BIN_W-1).
REQ-037 When BCD_SIGNED_EN is undefined, in_bin SHALL be treated as unsigned and out_neg SHALL be absent.

Verification
REQ-038 Defaults, in_bin=32'hFFFFFFFF -> out_bcd=40'h4294967295, out_ovf=0, out_valid 32 edges after accept.
REQ-039 in_bin=0 and in_bin=32'd1000000007 back-to-back, out_ready held 1 -> 40'h0 then 40'h1000000007; accepts are BIN_W+2 cycles apart.
REQ-040 BIN_W=8, N_DIGITS=2, in_bin=8'd255 -> out_bcd=8'h55, out_ovf=1; in_bin=8'd99 -> out_bcd=8'h99, out_ovf=0.
REQ-041 abort at counter=10, then rst_n pulse at counter=5 of the next operand -> out_valid never rises, in_ready=1 after each event; the next conversion is correct.
REQ-042 out_ready held 0 for 20 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored throughout.
REQ-043 BCD_SIGNED_EN, in_bin=32'hFFFFFFFF -> out_bcd=1, out_neg=1; in_bin=32'h80000000 -> out_bcd=40'h2147483648, out_neg=1.
